// File: rtl/pipe_control.sv
// Pipelined RV32I main control: decodes the opcode in ID and carries the control word through EX, MEM and WB.
// Define PIPE_CONTROL_ILLEGAL_EN to build the illegal-opcode flag and saturating counter.
module pipe_control #(
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [6:0]         Op_i,
    input  logic               NoOp_i,
    input  logic               Flush_i,
    input  logic               Freeze_i,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic               ALUSrc_o,
    output logic               AZero_o,
    output logic               Branch_o,
    output logic               Jal_o,
    output logic               Jalr_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               RegWrite_o,
    output logic [1:0]         WbSel_o,
    output logic               Illegal_o,
    output logic [CNT_W-1:0]   IllCnt_o
);

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               a_zero;
        logic               branch;
        logic               jal;
        logic               jalr;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic [1:0]         wb_sel;
    } ex_word_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
    } mem_word_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] wb_sel;
    } wb_word_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    ex_word_t  dec_word;
    ex_word_t  ex_p0;
    mem_word_t mem_p1;
    wb_word_t  wb_p2;
    logic      kill_ex;

    assign kill_ex = Flush_i | NoOp_i;

    always_comb begin
        dec_word = '0;
        case (Op_i)
            OP_R: begin
                dec_word.alu_op    = ALUOP_W'(2'b10);
                dec_word.reg_write = 1'b1;
            end
            OP_IMM: begin
                dec_word.alu_op    = ALUOP_W'(2'b11);
                dec_word.alu_src   = 1'b1;
                dec_word.reg_write = 1'b1;
            end
            OP_LOAD: begin
                dec_word.alu_src   = 1'b1;
                dec_word.mem_read  = 1'b1;
                dec_word.reg_write = 1'b1;
                dec_word.wb_sel    = 2'b01;
            end
            OP_STORE: begin
                dec_word.alu_src   = 1'b1;
                dec_word.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                dec_word.alu_op = ALUOP_W'(2'b01);
                dec_word.branch = 1'b1;
            end
            OP_JAL: begin
                dec_word.jal       = 1'b1;
                dec_word.reg_write = 1'b1;
                dec_word.wb_sel    = 2'b10;
            end
            OP_JALR: begin
                dec_word.alu_src   = 1'b1;
                dec_word.jalr      = 1'b1;
                dec_word.reg_write = 1'b1;
                dec_word.wb_sel    = 2'b10;
            end
            OP_LUI: begin
                dec_word.alu_src   = 1'b1;
                dec_word.a_zero    = 1'b1;
                dec_word.reg_write = 1'b1;
            end
            default: dec_word = '0;
        endcase
    end

    // ID -> EX -> MEM -> WB; a flush also kills the instruction leaving EX
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_p0  <= '0;
            mem_p1 <= '0;
            wb_p2  <= '0;
        end else if (!Freeze_i) begin
            ex_p0 <= kill_ex ? '0 : dec_word;
            if (Flush_i) begin
                mem_p1 <= '0;
            end else begin
                mem_p1.mem_read  <= ex_p0.mem_read;
                mem_p1.mem_write <= ex_p0.mem_write;
                mem_p1.reg_write <= ex_p0.reg_write;
                mem_p1.wb_sel    <= ex_p0.wb_sel;
            end
            wb_p2.reg_write <= mem_p1.reg_write;
            wb_p2.wb_sel    <= mem_p1.wb_sel;
        end
    end

    assign ALUOp_o    = ex_p0.alu_op;
    assign ALUSrc_o   = ex_p0.alu_src;
    assign AZero_o    = ex_p0.a_zero;
    assign Branch_o   = ex_p0.branch;
    assign Jal_o      = ex_p0.jal;
    assign Jalr_o     = ex_p0.jalr;
    assign MemRead_o  = mem_p1.mem_read;
    assign MemWrite_o = mem_p1.mem_write;
    assign RegWrite_o = wb_p2.reg_write;
    assign WbSel_o    = wb_p2.wb_sel;

`ifdef PIPE_CONTROL_ILLEGAL_EN
    logic             dec_illegal;
    logic             ill_p0;
    logic [CNT_W-1:0] ill_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // every legal opcode sets at least one control bit, so an all-zero decode is unknown
    assign dec_illegal = (dec_word == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ill_p0  <= 1'b0;
            ill_cnt <= '0;
        end else if (!Freeze_i) begin
            ill_p0 <= dec_illegal & ~kill_ex;
            if (dec_illegal && !kill_ex)
                ill_cnt <= sat_inc(ill_cnt);
        end
    end

    assign Illegal_o = ill_p0;
    assign IllCnt_o  = ill_cnt;
`else
    assign Illegal_o = 1'b0;
    assign IllCnt_o  = '0;
`endif

endmodule
